// File: rtl/game_sequencer_if.sv
// Signal bundle between the round controller and keypad/fsm/obstacle generator/display.
// obs_load is a one-cycle pulse with no back-pressure; the generator must present tipo_obs on the next cycle.
interface game_sequencer_if;
  logic [2:0] presente;
  logic       keypad_pressed;
  logic [4:0] key;
  logic [3:0] tipo_obs;
  logic       obs_load;
  logic [1:0] obs_pos;
  logic [1:0] hero_pose;
  logic       step;
  logic [7:0] score;
  logic [1:0] W_or_L;
  logic [2:0] dbg_state;

  modport slave (
    input  presente, keypad_pressed, key, tipo_obs,
    output obs_load, obs_pos, hero_pose, step, score, W_or_L, dbg_state
  );

  modport master (
    output presente, keypad_pressed, key, tipo_obs,
    input  obs_load, obs_pos, hero_pose, step, score, W_or_L, dbg_state
  );
endinterface

// File: rtl/game_sequencer.sv
// Hero-runner round controller: spawns obstacles, scrolls them on a divided tick,
// applies jump/duck poses from the keypad and resolves dodge/collision into a score and win/lose.
module game_sequencer #(
  parameter int             TICK_DIV   = 25_000_000,
  parameter int             LANE_LEN   = 4,
  parameter int             JUMP_TICKS = 2,
  parameter int             WIN_SCORE  = 20,
  parameter logic [2:0]     PLAY_STATE = 3'd3,
  parameter logic [4:0]     KEY_JUMP   = 5'd2,
  parameter logic [4:0]     KEY_DUCK   = 5'd8
) (
  input  logic              clk,
  input  logic              rst,
  game_sequencer_if.slave   bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int PW = $clog2(JUMP_TICKS + 1);
  localparam logic [1:0] POS_SPAWN = 2'(LANE_LEN - 1);

  localparam logic [1:0] POSE_RUN  = 2'b00;
  localparam logic [1:0] POSE_JUMP = 2'b01;
  localparam logic [1:0] POSE_DUCK = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_LATCH = 3'd2,
    S_RUN   = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_tick_cnt;
  logic [PW-1:0]   r_pose_cnt;
  logic            r_key_q;
  logic            r_aerial;
  logic            r_obs_load;
  logic [1:0]      r_obs_pos;
  logic [1:0]      r_pose;
  logic            r_step;
  logic [7:0]      r_score;
  logic [1:0]      r_wl;

  logic            w_play;
  logic            w_key_edge;
  logic            w_tick;
  logic            w_key_ok;
  logic            w_dodge;
  logic            w_win;
  logic [7:0]      w_score_next;

  assign w_play       = (bus.presente == PLAY_STATE);
  assign w_key_edge   = bus.keypad_pressed && !r_key_q;
  assign w_tick       = (r_state == S_RUN) && (r_tick_cnt == CW'(TICK_DIV - 1));
  assign w_key_ok     = (r_state == S_RUN) && (r_pose == POSE_RUN) && w_key_edge &&
                        ((bus.key == KEY_JUMP) || (bus.key == KEY_DUCK));
  assign w_dodge      = (r_aerial && (r_pose == POSE_DUCK)) || (!r_aerial && (r_pose == POSE_JUMP));
  assign w_win        = (({1'b0, r_score} + 9'd1) == 9'(WIN_SCORE));
  assign w_score_next = (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_pose_cnt <= '0;
      r_key_q    <= 1'b0;
      r_aerial   <= 1'b0;
      r_obs_load <= 1'b0;
      r_obs_pos  <= POS_SPAWN;
      r_pose     <= POSE_RUN;
      r_step     <= 1'b0;
      r_score    <= 8'd0;
      r_wl       <= 2'b00;
    end else begin
      r_key_q    <= bus.keypad_pressed;
      r_obs_load <= 1'b0;
      r_step     <= 1'b0;
      // Leaving the play screen aborts or closes the round from any active state.
      if ((r_state != S_IDLE) && !w_play) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= '0;
        r_pose_cnt <= '0;
        r_obs_pos  <= POS_SPAWN;
        r_pose     <= POSE_RUN;
        r_score    <= 8'd0;
        r_wl       <= 2'b00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_play) begin
              r_state    <= S_SPAWN;
              r_obs_load <= 1'b1;
              r_obs_pos  <= POS_SPAWN;
              r_tick_cnt <= '0;
            end
          end
          S_SPAWN: r_state <= S_LATCH;
          S_LATCH: begin
            r_aerial <= bus.tipo_obs[3];
            r_state  <= S_RUN;
          end
          S_RUN: begin
            if (w_tick) begin
              r_tick_cnt <= '0;
              r_step     <= 1'b1;
              if (r_obs_pos != 2'd0) begin
                r_obs_pos <= r_obs_pos - 2'd1;
                if (r_pose != POSE_RUN) begin
                  if (r_pose_cnt <= PW'(1)) begin
                    r_pose_cnt <= '0;
                    r_pose     <= POSE_RUN;
                  end else begin
                    r_pose_cnt <= r_pose_cnt - PW'(1);
                  end
                end
              end else if (w_dodge) begin
                r_score <= w_score_next;
                if (w_win) begin
                  r_wl    <= 2'b01;
                  r_state <= S_WIN;
                end else begin
                  r_state    <= S_SPAWN;
                  r_obs_load <= 1'b1;
                  r_obs_pos  <= POS_SPAWN;
                end
              end else begin
                r_wl    <= 2'b10;
                r_state <= S_LOSE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + CW'(1);
            end
            // A same-cycle tick already resolved against the old pose above.
            if (w_key_ok) begin
              r_pose     <= (bus.key == KEY_JUMP) ? POSE_JUMP : POSE_DUCK;
              r_pose_cnt <= PW'(JUMP_TICKS);
            end
          end
          S_WIN, S_LOSE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.obs_load  = r_obs_load;
  assign bus.obs_pos   = r_obs_pos;
  assign bus.hero_pose = r_pose;
  assign bus.step      = r_step;
  assign bus.score     = r_score;
  assign bus.W_or_L    = r_wl;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer: a rule-level model of the round predicts every output each cycle.
module tb_game_sequencer;
  localparam int         TICK_DIV   = 4;
  localparam int         LANE_LEN   = 4;
  localparam int         JUMP_TICKS = 2;
  localparam int         WIN_SCORE  = 2;
  localparam logic [2:0] PLAY       = 3'd3;
  localparam logic [4:0] KJ         = 5'd2;
  localparam logic [4:0] KD         = 5'd8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .TICK_DIV(TICK_DIV), .LANE_LEN(LANE_LEN), .JUMP_TICKS(JUMP_TICKS),
    .WIN_SCORE(WIN_SCORE), .PLAY_STATE(PLAY), .KEY_JUMP(KJ), .KEY_DUCK(KD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int wins  = 0;
  int losses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: mode 0 idle, 1 playing, 2 round over; age = cycles since spawn
  int m_mode, m_age, m_pos, m_pose, m_pcnt, m_score, m_wl, m_load, m_step, m_aer, m_kq;
  logic [1:0] exp_q[$];
  logic [1:0] prev_wl;

  task automatic clear_round();
    m_mode = 0; m_age = 0; m_pos = LANE_LEN - 1; m_pose = 0; m_pcnt = 0;
    m_score = 0; m_wl = 0; m_load = 0; m_step = 0;
  endtask

  task automatic start_obstacle();
    m_age = 0; m_load = 1; m_pos = LANE_LEN - 1;
  endtask

  task automatic model_step(input bit r, input bit play, input bit kp, input logic [4:0] k, input bit aer_in);
    bit edge_k, key_ok, tick;
    edge_k = kp && (m_kq == 0);
    if (r) begin
      clear_round();
      m_kq = 0;
      return;
    end
    m_kq = kp;
    m_load = 0;
    m_step = 0;
    if (m_mode == 0) begin
      if (play) begin
        m_mode = 1;
        start_obstacle();
      end
    end else if (!play) begin
      clear_round();
    end else if (m_mode == 1) begin
      if (m_age < 2) begin
        if (m_age == 1) m_aer = aer_in;
        m_age++;
      end else begin
        key_ok = edge_k && (m_pose == 0) && ((k == KJ) || (k == KD));
        tick = ((m_age - 2) % TICK_DIV) == (TICK_DIV - 1);
        m_age++;
        if (tick) begin
          m_step = 1;
          if (m_pos > 0) begin
            m_pos--;
            if (m_pose != 0) begin
              m_pcnt--;
              if (m_pcnt == 0) m_pose = 0;
            end
          end else if ((m_aer != 0 && m_pose == 2) || (m_aer == 0 && m_pose == 1)) begin
            if (m_score < 255) m_score++;
            if (m_score == WIN_SCORE) begin
              m_wl = 1; m_mode = 2; wins++;
              exp_q.push_back(2'b01);
            end else begin
              start_obstacle();
            end
          end else begin
            m_wl = 2; m_mode = 2; losses++;
            exp_q.push_back(2'b10);
          end
        end
        if (key_ok) begin
          m_pose = (k == KJ) ? 1 : 2;
          m_pcnt = JUMP_TICKS;
        end
      end
    end
  endtask

  // one clock: model advances with the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step(rst, bus.presente == PLAY, bus.keypad_pressed, bus.key, bus.tipo_obs[3]);
    @(negedge clk);
    check("obs_load",  32'(bus.obs_load),  32'(m_load));
    check("obs_pos",   32'(bus.obs_pos),   32'(m_pos));
    check("hero_pose", 32'(bus.hero_pose), 32'(m_pose));
    check("step",      32'(bus.step),      32'(m_step));
    check("score",     32'(bus.score),     32'(m_score));
    check("W_or_L",    32'(bus.W_or_L),    32'(m_wl));
    if (prev_wl == 2'b00 && bus.W_or_L != 2'b00) begin
      if (exp_q.size() == 0) check("result_unexpected", 32'(bus.W_or_L), 32'd0);
      else check("result", 32'(bus.W_or_L), 32'(exp_q.pop_front()));
    end
    prev_wl = bus.W_or_L;
  endtask

  // driver: a player that usually presses the right key near the hero, plus noise presses
  int hold = 0;
  task automatic drive_player();
    logic [4:0] noise[4];
    noise[0] = KJ; noise[1] = KD; noise[2] = 5'd5; noise[3] = 5'($urandom);
    if (hold > 0) begin
      hold--;
    end else if (bus.keypad_pressed) begin
      bus.keypad_pressed = 1'b0;
      bus.key = 5'($urandom);
    end else if (m_mode == 1 && m_age >= 2 && m_pose == 0 && m_pos <= 1 && $urandom_range(0, 9) < 8) begin
      bus.keypad_pressed = 1'b1;
      bus.key = (m_aer != 0) ? KD : KJ;
      hold = $urandom_range(0, 9);
    end else if ($urandom_range(0, 19) == 0) begin
      bus.keypad_pressed = 1'b1;
      bus.key = noise[$urandom_range(0, 3)];
      hold = $urandom_range(0, 9);
    end
  endtask

  initial begin
    int v;
    int len;
    rst = 1'b1;
    bus.presente = PLAY;
    bus.keypad_pressed = 1'b0;
    bus.key = 5'd0;
    bus.tipo_obs = 4'd0;
    prev_wl = 2'b00;
    clear_round();
    m_kq = 0;
    m_aer = 0;
    repeat (2) cycle();
    rst = 1'b0;

    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(20, 140);
      bus.presente = PLAY;
      for (int c = 0; c < len; c++) begin
        rst = ($urandom_range(0, 299) == 0);
        bus.tipo_obs = 4'($urandom);
        drive_player();
        cycle();
      end
      rst = 1'b0;
      v = $urandom_range(0, 6);
      if (v >= 3) v++;
      bus.presente = 3'(v);
      repeat (3) begin
        drive_player();
        cycle();
      end
    end

    check("result_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("rounds resolved: wins=%0d losses=%0d", wins, losses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
